// File: rtl/unpack_pkg.sv
// Shared constants and types for the FP MAC operand unpacker.
// Imported by unpack_lane and unpack_pipe.
package unpack_pkg;

   localparam logic OP_HALF   = 1'b0;
   localparam logic OP_SINGLE = 1'b1;

   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;
   localparam int FP16_EXP_W = 5;
   localparam int FP16_MAN_W = 10;

   localparam int CLS_ZERO = 0;
   localparam int CLS_INF  = 1;
   localparam int CLS_NAN  = 2;

   typedef struct packed {
      logic        s;
      logic [7:0]  e;
      logic [11:0] H;
      logic [11:0] L;
      logic [2:0]  cls;
   } unpacked_t;

endpackage

// File: rtl/unpack_lane.sv
// Combinational unpack of one 32-bit operand word (fp16 or fp32).
// Ports: i_w word, i_op 0=fp16/1=fp32, o_u sign/exp/H/L/class.
module unpack_lane
   import unpack_pkg::*;
(
   input  logic [31:0] i_w,
   input  logic        i_op,
   output unpacked_t   o_u
);

   logic [FP32_EXP_W-1:0] w_e32;
   logic [FP32_MAN_W-1:0] w_m32;
   logic [FP16_EXP_W-1:0] w_e16;
   logic [FP16_MAN_W-1:0] w_m16;
   logic                  w_ez;
   logic                  w_eo;
   logic                  w_mz;
   logic                  w_h;

   assign w_e32 = i_w[30:23];
   assign w_m32 = i_w[22:0];
   assign w_e16 = i_w[14:10];
   assign w_m16 = i_w[9:0];

   assign w_ez = (i_op == OP_SINGLE) ? (w_e32 == '0) : (w_e16 == '0);
   assign w_eo = (i_op == OP_SINGLE) ? (&w_e32)      : (&w_e16);
   assign w_mz = (i_op == OP_SINGLE) ? (w_m32 == '0) : (w_m16 == '0);
   assign w_h  = !w_ez;

   always_comb begin
      o_u = '0;
      if (i_op == OP_SINGLE) begin
         o_u.s = i_w[31];
         // subnormals report exponent 1 so they share the scale of the
         // smallest normal; true zero keeps exponent 0
         o_u.e = w_ez ? {7'b0, !w_mz} : w_e32;
         o_u.H = {w_h, w_m32[22:12]};
         o_u.L = w_m32[11:0];
      end else begin
         o_u.s = i_w[15];
         o_u.e = w_ez ? {7'b0, !w_mz} : {3'b0, w_e16};
         o_u.H = '0;
         o_u.L = {1'b0, w_h, w_m16};
      end
      o_u.cls[CLS_ZERO] = w_ez & w_mz;
      o_u.cls[CLS_INF]  = w_eo & w_mz;
      o_u.cls[CLS_NAN]  = w_eo & !w_mz;
   end

endmodule

// File: rtl/unpack_pipe.sv
// Two-stage valid/ready operand unpacker feeding the split multipliers.
// Ports: clk/rst_n/flush, in_* beat (op, x, y lanes), out_* unpacked fields.
module unpack_pipe
   import unpack_pkg::*;
#(
   parameter int LANES   = 4,
   parameter int SPLIT_W = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_op,
   input  logic [LANES*32-1:0]        in_x,
   input  logic [LANES*32-1:0]        in_y,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_op,
   output logic [2*LANES-1:0]         out_s,
   output logic [2*LANES*8-1:0]       out_e,
   output logic [2*LANES*SPLIT_W-1:0] out_H,
   output logic [2*LANES*SPLIT_W-1:0] out_L,
   output logic [2*LANES*3-1:0]       out_cls
);

   localparam int NK = 2 * LANES;

   logic                       r_v1;
   logic                       r_op1;
   logic [LANES*32-1:0]        r_x1;
   logic [LANES*32-1:0]        r_y1;

   logic                       r_v2;
   logic                       r_op2;
   logic [NK-1:0]              r_s2;
   logic [NK*8-1:0]            r_e2;
   logic [NK*SPLIT_W-1:0]      r_H2;
   logic [NK*SPLIT_W-1:0]      r_L2;
   logic [NK*3-1:0]            r_cls2;

   logic                       w_adv1;
   logic                       w_adv2;
   logic [NK-1:0]              w_s;
   logic [NK*8-1:0]            w_e;
   logic [NK*SPLIT_W-1:0]      w_H;
   logic [NK*SPLIT_W-1:0]      w_L;
   logic [NK*3-1:0]            w_cls;

   assign w_adv2   = !r_v2 | out_ready;
   assign w_adv1   = !r_v1 | w_adv2;
   assign in_ready = w_adv1;

   for (genvar k = 0; k < NK; k++) begin : g_lane
      logic [31:0] w_word;
      unpacked_t   w_u;

      if (k < LANES) begin : g_x
         assign w_word = r_x1[32*k +: 32];
      end else begin : g_y
         assign w_word = r_y1[32*(k-LANES) +: 32];
      end

      unpack_lane u_lane (
         .i_w  (w_word),
         .i_op (r_op1),
         .o_u  (w_u)
      );

      assign w_s[k]                   = w_u.s;
      assign w_e[8*k +: 8]            = w_u.e;
      assign w_H[SPLIT_W*k +: SPLIT_W] = w_u.H;
      assign w_L[SPLIT_W*k +: SPLIT_W] = w_u.L;
      assign w_cls[3*k +: 3]          = w_u.cls;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else if (flush) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else begin
         if (w_adv1) r_v1 <= in_valid;
         if (w_adv2) r_v2 <= r_v1;
      end
   end

   // data registers only load when a real beat moves in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op1 <= 1'b0;
         r_x1  <= '0;
         r_y1  <= '0;
      end else if (w_adv1 && in_valid) begin
         r_op1 <= in_op;
         r_x1  <= in_x;
         r_y1  <= in_y;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op2  <= 1'b0;
         r_s2   <= '0;
         r_e2   <= '0;
         r_H2   <= '0;
         r_L2   <= '0;
         r_cls2 <= '0;
      end else if (w_adv2 && r_v1) begin
         r_op2  <= r_op1;
         r_s2   <= w_s;
         r_e2   <= w_e;
         r_H2   <= w_H;
         r_L2   <= w_L;
         r_cls2 <= w_cls;
      end
   end

   assign out_valid = r_v2;
   assign out_op    = r_op2;
   assign out_s     = r_s2;
   assign out_e     = r_e2;
   assign out_H     = r_H2;
   assign out_L     = r_L2;
   assign out_cls   = r_cls2;

endmodule

// File: tb/tb_unpack_pipe.sv
// Directed and scoreboard bench for unpack_pipe.
// Drives and samples on the falling edge.
module tb_unpack_pipe;

   localparam int LANES = 4;
   localparam int NK    = 2 * LANES;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 flush = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic                 in_op = 1'b0;
   logic [LANES*32-1:0]  in_x = '0;
   logic [LANES*32-1:0]  in_y = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic                 out_op;
   logic [NK-1:0]        out_s;
   logic [NK*8-1:0]      out_e;
   logic [NK*12-1:0]     out_H;
   logic [NK*12-1:0]     out_L;
   logic [NK*3-1:0]      out_cls;

   int checks = 0;
   int errors = 0;

   logic [LANES*32-1:0]  qx[$];
   logic [LANES*32-1:0]  qy[$];
   logic                 qop[$];

   unpack_pipe #(.LANES(LANES), .SPLIT_W(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_x      (in_x),
      .in_y      (in_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_op    (out_op),
      .out_s     (out_s),
      .out_e     (out_e),
      .out_H     (out_H),
      .out_L     (out_L),
      .out_cls   (out_cls)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [319:0] obs,
                      input logic [319:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] mk(input logic s, input logic [7:0] e,
                                      input logic [11:0] h, input logic [11:0] l,
                                      input logic [2:0] c);
      return {s, e, h, l, c};
   endfunction

   function automatic logic [35:0] fld(input int k);
      return {out_s[k], out_e[8*k +: 8], out_H[12*k +: 12],
              out_L[12*k +: 12], out_cls[3*k +: 3]};
   endfunction

   function automatic logic [290:0] all_out();
      return {out_valid, out_op, out_s, out_e, out_H, out_L, out_cls};
   endfunction

   function automatic logic [35:0] model(input logic [31:0] w, input logic op);
      logic        s;
      logic [7:0]  ex;
      logic [22:0] fr;
      logic [23:0] sig;
      logic [11:0] h;
      logic [11:0] l;
      logic        ones;
      logic        fz;
      logic [2:0]  c;
      if (op) begin
         s    = w[31];
         ex   = w[30:23];
         fr   = w[22:0];
         ones = (ex == 8'hFF);
      end else begin
         s    = w[15];
         ex   = {3'b000, w[14:10]};
         fr   = {13'b0, w[9:0]};
         ones = (ex == 8'h1F);
      end
      fz  = (fr == 23'd0);
      c   = {ones && !fz, ones && fz, (ex == 8'd0) && fz};
      sig = {(ex != 8'd0), fr};
      if (op) begin
         h = sig[23:12];
         l = sig[11:0];
      end else begin
         h = 12'h000;
         l = {1'b0, (ex != 8'd0), fr[9:0]};
      end
      if (ex == 8'd0 && !fz) ex = 8'd1;
      return {s, ex, h, l, c};
   endfunction

   function automatic logic [LANES*32-1:0] pat_x(input int b);
      logic [LANES*32-1:0] v;
      for (int i = 0; i < LANES; i++)
         v[32*i +: 32] = 32'h3F80_0000 + 32'(b) * 32'h0001_0101 + 32'(i) * 32'h00C0_0007;
      v[63:32] = (b % 3 == 0) ? 32'h7F80_0000 : v[63:32];
      return v;
   endfunction

   function automatic logic [LANES*32-1:0] pat_y(input int b);
      logic [LANES*32-1:0] v;
      v = ~pat_x(b);
      v[31:0] = 32'(b) * 32'h0000_0023;
      return v;
   endfunction

   task automatic send_beat(input logic op, input logic [LANES*32-1:0] x,
                            input logic [LANES*32-1:0] y);
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = op;
      in_x     = x;
      in_y     = y;
      #1;
      chk("accept_rdy", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("lat_early", out_valid, 1'b0);
      @(negedge clk);
      #1;
      chk("lat2", out_valid, 1'b1);
      chk("op", out_op, op);
   endtask

   task automatic run_stream(input int n, input bit alt);
      int   sent = 0;
      int   got  = 0;
      int   cyc  = 0;
      int   occ;
      bit   hold = 1'b0;
      logic [290:0] held = '0;
      logic [LANES*32-1:0] ex_x;
      logic [LANES*32-1:0] ex_y;
      logic ex_op;
      while (got < n && cyc < 300) begin
         @(negedge clk);
         out_ready = alt ? 1'b1 : 1'($urandom_range(0, 1));
         if (sent < n) begin
            in_valid = 1'b1;
            in_op    = alt ? 1'(sent) : 1'b1;
            in_x     = pat_x(sent);
            in_y     = pat_y(sent);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (hold) chk("stall_hold", all_out(), held);
         occ = sent - got;
         chk("in_ready", in_ready, (occ < 2) || out_ready);
         if (alt && sent >= 2) chk("no_bubble", out_valid, 1'b1);
         if (out_valid && out_ready) begin
            if (qop.size() == 0) begin
               chk("spurious", 1'b1, 1'b0);
            end else begin
               ex_x  = qx.pop_front();
               ex_y  = qy.pop_front();
               ex_op = qop.pop_front();
               chk("sb_op", out_op, ex_op);
               for (int k = 0; k < NK; k++)
                  chk($sformatf("sb_k%0d_b%0d", k, got), fld(k),
                      model(k < LANES ? ex_x[32*k +: 32] : ex_y[32*(k-LANES) +: 32], ex_op));
            end
            got++;
         end
         hold = out_valid && !out_ready;
         held = all_out();
         if (in_valid && in_ready) begin
            qx.push_back(in_x);
            qy.push_back(in_y);
            qop.push_back(in_op);
            sent++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_cnt", got, n);
   endtask

   initial begin
      logic [LANES*32-1:0] x;
      logic [LANES*32-1:0] y;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_outs", all_out(), '0);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", in_ready, 1'b1);

      x = '0; y = '0;
      x[31:0] = 32'h3F80_0000;
      send_beat(1'b1, x, y);
      chk("t1_x0", fld(0), mk(1'b0, 8'h7F, 12'h800, 12'h000, 3'b000));
      chk("t1_y0", fld(LANES), mk(1'b0, 8'h00, 12'h000, 12'h000, 3'b001));

      x = '0; y = '0;
      x[63:32]  = 32'h0000_0001;
      y[127:96] = 32'hABCD_3C00;
      send_beat(1'b0, x, y);
      chk("t2_y3", fld(LANES + 3), mk(1'b0, 8'h0F, 12'h000, 12'h400, 3'b000));
      chk("t2_x1", fld(1), mk(1'b0, 8'h01, 12'h000, 12'h001, 3'b000));
      chk("t2_x0", fld(0), mk(1'b0, 8'h00, 12'h000, 12'h000, 3'b001));

      x = {32'h0000_0000, 32'h0000_0001, 32'hFF80_0000, 32'h7FC0_0000};
      y = '0;
      y[31:0]  = 32'h8000_0000;
      y[63:32] = 32'h0040_0000;
      send_beat(1'b1, x, y);
      chk("t3_nan32", fld(0), mk(1'b0, 8'hFF, 12'hC00, 12'h000, 3'b100));
      chk("t3_ninf32", fld(1), mk(1'b1, 8'hFF, 12'h800, 12'h000, 3'b010));
      chk("t3_sub32", fld(2), mk(1'b0, 8'h01, 12'h000, 12'h001, 3'b000));
      chk("t3_nz32", fld(LANES), mk(1'b1, 8'h00, 12'h000, 12'h000, 3'b001));
      chk("t3_subh32", fld(LANES + 1), mk(1'b0, 8'h01, 12'h400, 12'h000, 3'b000));

      x = {32'h0000_03FF, 32'h0000_7E00, 32'h0000_7C00, 32'h0000_8000};
      y = '0;
      send_beat(1'b0, x, y);
      chk("t3_nz16", fld(0), mk(1'b1, 8'h00, 12'h000, 12'h000, 3'b001));
      chk("t3_inf16", fld(1), mk(1'b0, 8'h1F, 12'h000, 12'h400, 3'b010));
      chk("t3_nan16", fld(2), mk(1'b0, 8'h1F, 12'h000, 12'h600, 3'b100));
      chk("t3_sub16", fld(3), mk(1'b0, 8'h01, 12'h000, 12'h3FF, 3'b000));

      run_stream(10, 1'b0);
      run_stream(10, 1'b1);

      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op     = 1'b1;
      in_x      = pat_x(1);
      in_y      = pat_y(1);
      @(negedge clk);
      in_x      = pat_x(2);
      @(negedge clk);
      in_valid  = 1'b0;
      #1;
      chk("fill_valid", out_valid, 1'b1);
      chk("fill_rdy", in_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", out_valid, 1'b0);
      chk("mrst_outs", all_out(), '0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("mrst_idle", out_valid, 1'b0);
      end

      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_x      = pat_x(3);
      @(negedge clk);
      in_x      = pat_x(4);
      @(negedge clk);
      flush     = 1'b1;
      in_x      = pat_x(5);
      @(negedge clk);
      flush     = 1'b0;
      in_valid  = 1'b0;
      #1;
      chk("flush_clr", out_valid, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk("flush_drop", out_valid, 1'b0);
      end

      x = '0; y = '0;
      x[31:0] = 32'h4049_0FDB;
      send_beat(1'b1, x, y);
      chk("post_flush", fld(0), mk(1'b0, 8'h80, 12'hC90, 12'hFDB, 3'b000));
      @(negedge clk);
      #1;
      chk("post_drain", out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
